// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM states, default sizes and fill-select encoding.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_t;

  // Rotation wins over arithmetic fill when both are requested.
  function automatic fill_t fill_select(input logic rotate, input logic arith);
    if (rotate)     return FILL_ROT;
    else if (arith) return FILL_SIGN;
    else            return FILL_ZERO;
  endfunction

endpackage

// File: rtl/shift_datapath.sv
// WIDTH-bit register with synchronous reset, parallel load and a one-bit right shift
// whose incoming MSB is chosen by the fill-select code.
module shift_datapath
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift_en,
  input  logic [1:0]       i_fill_sel,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic             w_fill;

  always_comb begin
    w_fill = 1'b0;
    case (i_fill_sel)
      FILL_SIGN: w_fill = r_q[WIDTH-1];
      FILL_ROT:  w_fill = r_q[0];
      default:   w_fill = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift_en) begin
      r_q <= {w_fill, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for the load/shift datapath: one command per handshake, exactly
// cmd_count shift cycles, then a one-cycle done pulse. Optional rotate: SHIFT_SEQUENCER_ROTATE_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_arith,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_arith;
  logic             r_rotate;
  logic             w_accept;
  logic             w_shift_en;
  fill_t            w_fill_sel;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready
  // is high only in IDLE, and command fields are sampled only on that edge.
  assign w_accept = cmd_valid && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    w_shift_en = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = (cmd_count != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy       = 1'b1;
        w_shift_en = 1'b1;
        if (r_remaining == CNT_ONE) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_arith     <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= cmd_count;
      r_arith     <= cmd_arith;
    end else if (w_shift_en) begin
      r_remaining <= r_remaining - CNT_ONE;
    end
  end

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rotate <= 1'b0;
    end else if (w_accept) begin
      r_rotate <= cmd_rotate;
    end
  end
`else
  assign r_rotate = 1'b0;
`endif

  assign w_fill_sel = fill_select(r_rotate, r_arith);

  shift_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_load_data (cmd_data),
    .i_shift_en  (w_shift_en),
    .i_fill_sel  (w_fill_sel),
    .o_q         (q)
  );

  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a vector table of single commands plus hand-written
// sequences for reset abort, reset priority and back-to-back acceptance.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [3:0] cmd_count;
  logic       cmd_arith;
  logic       cmd_rotate;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .cmd_arith (cmd_arith),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .cmd_rotate(cmd_rotate),
`endif
    .busy      (busy),
    .done      (done),
    .q         (q),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] count;
    logic       arith;
    logic       rotate;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_shift(input logic [7:0] d, input int k,
                                             input logic arith, input logic rot);
    logic [7:0] r;
    r = d;
    if (ROT_EN && rot) begin
      for (int i = 0; i < k; i++) r = {r[0], r[7:1]};
    end else if (arith) begin
      r = $signed(d) >>> k;
    end else begin
      r = d >> k;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_data   = v.data;
    cmd_count  = v.count;
    cmd_arith  = v.arith;
    cmd_rotate = v.rotate;
    step();
    // Scramble the command fields: they must be ignored after the accepting edge.
    cmd_valid  = 1'b0;
    cmd_data   = ~v.data;
    cmd_count  = ~v.count;
    cmd_arith  = ~v.arith;
    cmd_rotate = ~v.rotate;
    chk({tag, "_load"}, 32'(q), 32'(v.data));
    for (int k = 1; k <= int'(v.count); k++) begin
      chk($sformatf("%s_busy_done_ready_k%0d", tag, k), 32'({busy, done, cmd_ready}), 32'b100);
      step();
      chk($sformatf("%s_q_k%0d", tag, k), 32'(q), 32'(model_shift(v.data, k, v.arith, v.rotate)));
    end
    chk({tag, "_done_pulse"}, 32'({busy, done, cmd_ready}), 32'b010);
    chk({tag, "_final_q"}, 32'(q), 32'(v.exp_q));
    step();
    chk({tag, "_after_done"}, 32'({busy, done, cmd_ready}), 32'b001);
    chk({tag, "_q_hold"}, 32'(q), 32'(v.exp_q));
  endtask

  initial begin
    int last_acc;
    int n_acc;
    logic acc;

    vecs[0]  = '{8'hA5, 4'd0,  1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{8'h96, 4'd3,  1'b1, 1'b0, 8'hF2};
    vecs[2]  = '{8'h96, 4'd3,  1'b0, 1'b0, 8'h12};
    vecs[3]  = '{8'hFF, 4'd15, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{8'h80, 4'd15, 1'b1, 1'b0, 8'hFF};
    vecs[5]  = '{8'h80, 4'd7,  1'b1, 1'b0, 8'hFF};
    vecs[6]  = '{8'h7F, 4'd8,  1'b1, 1'b0, 8'h00};
    vecs[7]  = '{8'h3C, 4'd2,  1'b0, 1'b0, 8'h0F};
    vecs[8]  = '{8'hC3, 4'd4,  1'b1, 1'b0, 8'hFC};
    vecs[9]  = '{8'h01, 4'd1,  1'b0, 1'b0, 8'h00};
    // Rotate and arithmetic shift of 0x81 by one both give 0xC0.
    vecs[10] = '{8'h81, 4'd1,  1'b1, 1'b1, 8'hC0};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = 8'h00;
    cmd_count  = 4'd0;
    cmd_arith  = 1'b0;
    cmd_rotate = 1'b0;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset_q_c%0d", i), 32'(q), 32'h00);
      chk($sformatf("reset_ctrl_c%0d", i), 32'({busy, done, cmd_ready}), 32'b001);
      step();
    end
    chk("reset_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset during the second SHIFT cycle of a count=5 command aborts it.
    cmd_valid = 1'b1; cmd_data = 8'h96; cmd_count = 4'd5; cmd_arith = 1'b0; cmd_rotate = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_q_mid", 32'(q), 32'h4B);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_ctrl", 32'({busy, done, cmd_ready}), 32'b001);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_count = 4'd2; cmd_arith = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("abort_reaccept_q", 32'(q), 32'h3C);
    step();
    step();
    chk("abort_reaccept_done", 32'({done, q}), 32'({1'b1, 8'h0F}));
    step();

    // Reset outranks a simultaneous command.
    reset = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h55; cmd_count = 4'd0;
    step();
    reset = 1'b0; cmd_valid = 1'b0;
    chk("prio_q", 32'(q), 32'h00);
    chk("prio_state", 32'(dbg_state), 32'(IDLE));
    step();
    chk("prio_no_done", 32'({done, q}), 32'h000);

    // cmd_valid held high: acceptances land exactly count+2 edges apart.
    cmd_valid = 1'b1; cmd_data = 8'hF0; cmd_count = 4'd2; cmd_arith = 1'b0;
    last_acc = -1;
    n_acc = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) begin
        chk($sformatf("b2b_q_e%0d", cyc), 32'(q), 32'hF0);
        if (last_acc >= 0) chk($sformatf("b2b_gap_e%0d", cyc), 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        n_acc++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_count", 32'(n_acc), 32'd4);
    for (int i = 0; i < 10 && !cmd_ready; i++) step();
    chk("b2b_drain_ready", 32'(cmd_ready), 32'd1);
    chk("b2b_final_q", 32'(q), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the 8-bit load/shift-right/arithmetic-shift register datapath. It accepts one command per handshake: a load value, a shift count and an arithmetic flag. It then drives the datapath's load, shift and fill controls for exactly the requested number of cycles, and reports completion with a one-cycle pulse. It sits between a requesting FSM or switch-decoder front end and the register, replacing manual per-clock key presses.

## Interface
Parameters:
- WIDTH, 8, datapath register width
- CNT_W, 4, width of shift-count field (max count 2^CNT_W-1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_data  in  WIDTH  value loaded into the register
- cmd_count  in  CNT_W  number of right shifts to perform
- cmd_arith  in  1  1 = arithmetic (MSB replicated), 0 = logical (zero fill)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- q  out  WIDTH  current register contents

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready, on the same edge: q<=cmd_data; remaining<=cmd_count; arith latched.
  - Next state is SHIFT if cmd_count!=0, else DONE.
- SHIFT:
  - Each cycle: q<={fill, q[WIDTH-1:1]}, with fill = arith ? q[WIDTH-1] : 0.
  - remaining decrements each cycle; leave for DONE on the edge where remaining==1.
- DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0; next state IDLE.
- cmd_ready=1 only in IDLE. cmd_data, cmd_count and cmd_arith are ignored outside the accepting edge.
- Counts >= WIDTH are legal. The result saturates to all-zero (logical) or all-sign (arithmetic), and the controller still spends the full count cycles.
- q holds its value in IDLE and DONE.

## Timing
- Reset values: state=IDLE, q=0, remaining=0, cmd_ready=1, busy=0, done=0.
- Acceptance at edge E0:
  - q=cmd_data is visible after E0.
  - After edge E0+k (k <= count), q reflects k shifts.
  - done is high in the cycle after edge E0+count (count=0: cycle after E0).
  - Earliest next acceptance is at edge E0+count+2.
- busy is high from after E0 through the last SHIFT cycle.
- Reset asserted mid-command aborts it. Next cycle: IDLE, q=0, no done pulse.
- Reset has priority over a simultaneous cmd_valid.
- A cmd_valid held high through DONE is accepted in the following IDLE cycle.

## Configuration
- SHIFT_SEQUENCER_ROTATE_EN defined:
  - Adds input cmd_rotate (1 bit), latched at acceptance.
  - When latched high, fill = q[0] (rotate right), taking priority over arith.
- Not defined: no cmd_rotate port; fill is governed by cmd_arith only.

## Structure
- Shared package shift_seq_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default WIDTH/CNT_W localparams;
  - the fill-select encoding (FILL_ZERO, FILL_SIGN, FILL_ROT).
- One sub-module, shift_datapath: WIDTH-bit register with sync reset, load, shift_en and fill inputs.
  - The controller FSM and counter live in shift_sequencer and drive only those control inputs.

## Test plan
- Reset then idle: q=0x00, cmd_ready=1, busy=0, done=0 for 5 cycles.
- cmd_data=0xA5, count=0 -> q=0xA5 after accept edge; done pulse next cycle; q stays 0xA5.
- cmd_data=0x96, count=3, arith=1 -> q=0xCB, 0xE5, 0xF2 on successive edges; done one cycle after the third shift; cmd_ready low throughout.
- cmd_data=0x96, count=3, arith=0 -> q=0x4B, 0x25, 0x12; then count=15 logical from 0xFF -> q=0x00, done 16 cycles after accept.
- Reset asserted at second SHIFT cycle of count=5 -> q=0x00, IDLE next cycle, no done pulse; a new command is accepted immediately after release.
- With SHIFT_SEQUENCER_ROTATE_EN: cmd_data=0x81, count=1, cmd_rotate=1, arith=1 -> q=0xC0. Back-to-back commands with cmd_valid held high are accepted exactly count+2 edges apart.
